alu_exec: RTL

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - two-stage integer ALU with 4-entry result FIFO onto the CDB (optional branch unit: ALU_BRANCH_EN)
module alu_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        RS_enable,
  input  logic [5:0]  RS_OP_ID,
  input  logic [31:0] RS_pc,
  input  logic [31:0] RS_reg_rs1,
  input  logic [31:0] RS_reg_rs2,
  input  logic [31:0] RS_imm,
  input  logic [3:0]  RS_ROB_id,
  output logic        ALU_busy,
  input  logic        flush,
  input  logic        CDB_grant,
  output logic        CDB_valid,
  output logic [3:0]  CDB_ROB_id,
  output logic [31:0] CDB_value
`ifdef ALU_BRANCH_EN
  ,
  output logic        CDB_jump,
  output logic [31:0] CDB_target
`endif
);

  // S1: registered dispatch
  logic        r_s1_valid;
  logic [5:0]  r_s1_op;
  logic [31:0] r_s1_pc;
  logic [31:0] r_s1_rs1;
  logic [31:0] r_s1_rs2;
  logic [31:0] r_s1_imm;
  logic [3:0]  r_s1_rob;

  // S2: computed result waiting to enter the FIFO
  logic        r_s2_valid;
  logic [31:0] r_s2_value;
  logic [3:0]  r_s2_rob;

  // result FIFO
  logic [31:0] r_fifo_value [4];
  logic [3:0]  r_fifo_rob   [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;

`ifdef ALU_BRANCH_EN
  logic        r_s2_jump;
  logic [31:0] r_s2_target;
  logic        r_fifo_jump   [4];
  logic [31:0] r_fifo_target [4];
  logic        w_jump;
  logic [31:0] w_target;
`endif

  logic [31:0] w_b;
  logic [4:0]  w_shamt;
  logic [31:0] w_value;
  logic [3:0]  w_inflight;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;

  // Back-pressure counts every slot that will eventually need a FIFO entry,
  // so the FIFO can never overflow even though S2 pushes unconditionally.
  assign w_inflight = {1'b0, r_count} + {3'd0, r_s1_valid} + {3'd0, r_s2_valid};
  assign ALU_busy   = (w_inflight >= 4'd4);
  assign w_accept   = RS_enable && !ALU_busy;
  assign w_push     = r_s2_valid;
  assign w_pop      = CDB_grant && (r_count != 3'd0);

  assign CDB_valid  = (r_count != 3'd0);
  assign CDB_ROB_id = r_fifo_rob[r_rd_ptr];
  assign CDB_value  = r_fifo_value[r_rd_ptr];
`ifdef ALU_BRANCH_EN
  assign CDB_jump   = r_fifo_jump[r_rd_ptr];
  assign CDB_target = r_fifo_target[r_rd_ptr];
`endif

  assign w_b     = r_s1_op[5] ? r_s1_imm : r_s1_rs2;
  assign w_shamt = w_b[4:0];

  // Execute: result value (and branch outcome) from the S1 operands
  always_comb begin
    w_value = 32'd0;
    case (r_s1_op[4:0])
      5'd0:  w_value = r_s1_rs1 + w_b;
      5'd1:  w_value = r_s1_op[5] ? (r_s1_rs1 + w_b) : (r_s1_rs1 - w_b);
      5'd2:  w_value = r_s1_rs1 & w_b;
      5'd3:  w_value = r_s1_rs1 | w_b;
      5'd4:  w_value = r_s1_rs1 ^ w_b;
      5'd5:  w_value = r_s1_rs1 << w_shamt;
      5'd6:  w_value = r_s1_rs1 >> w_shamt;
      5'd7:  w_value = 32'($signed(r_s1_rs1) >>> w_shamt);
      5'd8:  w_value = {31'd0, ($signed(r_s1_rs1) < $signed(w_b))};
      5'd9:  w_value = {31'd0, (r_s1_rs1 < w_b)};
      5'd10: w_value = r_s1_imm;
      5'd11: w_value = r_s1_pc + r_s1_imm;
      5'd12: w_value = r_s1_pc + 32'd4;
      default: w_value = 32'd0;
    endcase
`ifdef ALU_BRANCH_EN
    w_jump   = 1'b0;
    w_target = r_s1_pc + r_s1_imm;
    case (r_s1_op[4:0])
      5'd12: begin
        w_jump = 1'b1;
        if (r_s1_op[5]) w_target = (r_s1_rs1 + r_s1_imm) & ~32'd1;
      end
      5'd16: w_jump = (r_s1_rs1 == r_s1_rs2);
      5'd17: w_jump = (r_s1_rs1 != r_s1_rs2);
      5'd18: w_jump = ($signed(r_s1_rs1) <  $signed(r_s1_rs2));
      5'd19: w_jump = ($signed(r_s1_rs1) >= $signed(r_s1_rs2));
      5'd20: w_jump = (r_s1_rs1 <  r_s1_rs2);
      5'd21: w_jump = (r_s1_rs1 >= r_s1_rs2);
      default: w_jump = 1'b0;
    endcase
`endif
  end

  // S1 register: capture an accepted dispatch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= 6'd0;
      r_s1_pc    <= 32'd0;
      r_s1_rs1   <= 32'd0;
      r_s1_rs2   <= 32'd0;
      r_s1_imm   <= 32'd0;
      r_s1_rob   <= 4'd0;
    end else if (rdy) begin
      if (flush) begin
        r_s1_valid <= 1'b0;
      end else begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_op  <= RS_OP_ID;
          r_s1_pc  <= RS_pc;
          r_s1_rs1 <= RS_reg_rs1;
          r_s1_rs2 <= RS_reg_rs2;
          r_s1_imm <= RS_imm;
          r_s1_rob <= RS_ROB_id;
        end
      end
    end
  end

  // S2 register: hold the computed result for one cycle before the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_value  <= 32'd0;
      r_s2_rob    <= 4'd0;
`ifdef ALU_BRANCH_EN
      r_s2_jump   <= 1'b0;
      r_s2_target <= 32'd0;
`endif
    end else if (rdy) begin
      if (flush) begin
        r_s2_valid <= 1'b0;
      end else begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_value  <= w_value;
          r_s2_rob    <= r_s1_rob;
`ifdef ALU_BRANCH_EN
          r_s2_jump   <= w_jump;
          r_s2_target <= w_target;
`endif
        end
      end
    end
  end

  // Result FIFO: push from S2, pop on CDB grant, in dispatch order
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        r_fifo_value[i]  <= 32'd0;
        r_fifo_rob[i]    <= 4'd0;
`ifdef ALU_BRANCH_EN
        r_fifo_jump[i]   <= 1'b0;
        r_fifo_target[i] <= 32'd0;
`endif
      end
    end else if (rdy) begin
      if (flush) begin
        r_wr_ptr <= 2'd0;
        r_rd_ptr <= 2'd0;
        r_count  <= 3'd0;
      end else begin
        if (w_push) begin
          r_fifo_value[r_wr_ptr]  <= r_s2_value;
          r_fifo_rob[r_wr_ptr]    <= r_s2_rob;
`ifdef ALU_BRANCH_EN
          r_fifo_jump[r_wr_ptr]   <= r_s2_jump;
          r_fifo_target[r_wr_ptr] <= r_s2_target;
`endif
          r_wr_ptr <= r_wr_ptr + 2'd1;
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 3'd1;
          2'b01:   r_count <= r_count - 3'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule
